// File: rtl/ringbuffer_ctrl.sv
// ringbuffer_ctrl
// Pointer and flag controller for a power-of-two ring buffer of 2**BITS
// entries. It holds no data. It tracks the next write slot and the next
// read slot of an external RAM, and it flags empty and full.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   reset       synchronous, active-high; clears pointers and flags
//   write_done  producer strobe; each 0->1 transition is one completed write
//   read_done   consumer strobe; each 0->1 transition is one completed read
//   write_addr  registered slot for the next write
//   read_addr   registered slot for the next read
//   empty       registered; high when the buffer holds 0 entries
//   full        registered; high when the buffer holds 2**BITS entries
module ringbuffer_ctrl #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_done,
  input  logic            read_done,
  output logic [BITS-1:0] write_addr,
  output logic [BITS-1:0] read_addr,
  output logic            empty,
  output logic            full
);

  localparam logic [BITS-1:0] PTR_ONE = BITS'(1);
  localparam logic [BITS:0]   CNT_ONE = (BITS+1)'(1);
  localparam logic [BITS:0]   CNT_CAP = {1'b1, {BITS{1'b0}}};

  logic            wr_prev_q, rd_prev_q;
  logic [BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BITS:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  logic wr_ev, rd_ev, wr_ok, rd_ok;

  // Rising-edge detection: a strobe held high counts exactly once.
  assign wr_ev = write_done & ~wr_prev_q;
  assign rd_ev = read_done  & ~rd_prev_q;

  // Acceptance uses the flags from before this edge; a rejected event is
  // simply dropped.
  assign wr_ok = wr_ev & ~full_q;
  assign rd_ok = rd_ev & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    // A simultaneous write and read leaves occupancy unchanged.
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Flags are registered from the next occupancy. This resolves the case
    // where the two pointers are equal, which can mean empty or full.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_CAP);
  end

  always_ff @(posedge clk) begin
    // The strobe history follows its input during reset as well. A strobe
    // already high at release is therefore not counted.
    wr_prev_q <= write_done;
    rd_prev_q <= read_done;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign write_addr = wr_ptr_q;
  assign read_addr  = rd_ptr_q;
  assign empty      = empty_q;
  assign full       = full_q;

endmodule

// File: tb/tb_ringbuffer_ctrl.sv
// Directed testbench for ringbuffer_ctrl with BITS=4 (16 slots).
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// Observed state is packed as {write_addr, read_addr, empty, full}.
module tb_ringbuffer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_done = 1'b0;
  logic       read_done = 1'b0;
  logic [3:0] write_addr, read_addr;
  logic       empty, full;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  ringbuffer_ctrl #(.BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_done (write_done),
    .read_done  (read_done),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  assign obs = {write_addr, read_addr, empty, full};

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One strobe on the chosen inputs: high for 1 cycle, then low for 1 cycle.
  task automatic pulse(input bit w, input bit r);
    @(negedge clk);
    write_done = w;
    read_done  = r;
    @(negedge clk);
    write_done = 1'b0;
    read_done  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_fill();
    do_reset();
    pulse(1'b1, 1'b0);
    checks++;
    if (obs !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fill_first: got %h expected %h", obs, {4'd1, 4'd0, 1'b0, 1'b0});
    end
    repeat (14) pulse(1'b1, 1'b0);
    checks++;
    if (obs !== {4'd15, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fill_15: got %h expected %h", obs, {4'd15, 4'd0, 1'b0, 1'b0});
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fill_full: got %h expected %h", obs, {4'd0, 4'd0, 1'b0, 1'b1});
    end
  endtask

  // This test starts from the full state left by test_fill.
  task automatic test_overflow_underflow();
    repeat (3) pulse(1'b1, 1'b0);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got %h expected %h", obs, {4'd0, 4'd0, 1'b0, 1'b1});
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (obs !== {4'd0, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drain_first: got %h expected %h", obs, {4'd0, 4'd1, 1'b0, 1'b0});
    end
    repeat (15) pulse(1'b0, 1'b1);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drain_empty: got %h expected %h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL underflow: got %h expected %h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_held_strobe();
    do_reset();
    @(negedge clk);
    write_done = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (obs !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL held_once: got %h expected %h", obs, {4'd1, 4'd0, 1'b0, 1'b0});
    end
    write_done = 1'b0;
    // The strobe is held high across reset release and must never count.
    @(negedge clk);
    reset = 1'b1;
    write_done = 1'b1;
    read_done = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL held_reset: got %h expected %h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
    end
    write_done = 1'b0;
    read_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) pulse(1'b1, 1'b0);
    repeat (4) pulse(1'b1, 1'b1);
    checks++;
    if (obs !== {4'd9, 4'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_mid: got %h expected %h", obs, {4'd9, 4'd4, 1'b0, 1'b0});
    end
    do_reset();
    pulse(1'b1, 1'b1);
    checks++;
    if (obs !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_empty: got %h expected %h", obs, {4'd1, 4'd0, 1'b0, 1'b0});
    end
    do_reset();
    repeat (16) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    checks++;
    if (obs !== {4'd0, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL simul_full: got %h expected %h", obs, {4'd0, 4'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    checks++;
    if (obs !== {4'd8, 4'd8, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap: got %h expected %h", obs, {4'd8, 4'd8, 1'b1, 1'b0});
    end
    repeat (3) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++;
    if (obs !== {4'd11, 4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", obs, {4'd11, 4'd9, 1'b0, 1'b0});
    end
    // Reset is asserted on the same edge as a write strobe and must win.
    @(negedge clk);
    reset = 1'b1;
    write_done = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
    end
    reset = 1'b0;
    write_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_underflow();
    test_held_strobe();
    test_simultaneous();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
